// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between instruction fetch and load/store
// Ports: clk/rst; if_* fetch requester; dm_* data requester; mem_* memory side;
//        stall_if/stall_mem freeze the pipeline until the owner's access completes; busy = not IDLE.
module mem_port_arbiter #(
    parameter int ADDR_W     = 7,
    parameter int MEM_LAT    = 1,
    parameter int MAX_STARVE = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ready,
    output logic [31:0]       if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [2:0]        dm_funct3,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [31:0]       dm_wdata,
    output logic              dm_ready,
    output logic [31:0]       dm_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [2:0]        mem_funct3,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              stall_if,
    output logic              stall_mem,
    output logic              busy
);
    localparam int SW = $clog2(MAX_STARVE + 2);
    localparam logic [SW-1:0] STARVE_MAX = SW'(MAX_STARVE);
    localparam logic [3:0] LAT_LAST = 4'(MEM_LAT - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t              r_state, w_next;
    logic [3:0]          r_cnt;
    logic [SW-1:0]       r_starve;
    logic                r_own_dm, r_we;
    logic [2:0]          r_funct3;
    logic [ADDR_W-1:0]   r_addr;
    logic [31:0]         r_wdata, r_if_rdata, r_dm_rdata;
    logic                w_grant_dm, w_start, w_access, w_last;

    always_comb begin
        w_grant_dm = dm_req & ~(if_req & (r_starve == STARVE_MAX));
        w_start    = (r_state == IDLE) & (if_req | dm_req);
        w_access   = r_state == ACCESS;
        w_last     = w_access & (r_cnt == 4'd0);
        w_next     = w_start ? ACCESS : w_last ? RESP : (r_state == RESP) ? IDLE : r_state;
        mem_en     = w_access;
        mem_we     = w_access & r_we;
        mem_funct3 = w_access ? r_funct3 : 3'd0;
        mem_addr   = w_access ? r_addr : '0;
        mem_wdata  = w_access ? r_wdata : 32'd0;
        if_ready   = (r_state == RESP) & ~r_own_dm;
        dm_ready   = (r_state == RESP) & r_own_dm;
        // rst gating keeps the stalls low while reset is held
        stall_if   = ~rst & if_req & ~if_ready;
        stall_mem  = ~rst & dm_req & ~dm_ready;
        busy       = r_state != IDLE;
        if_rdata   = r_if_rdata;
        dm_rdata   = r_dm_rdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_own_dm   <= 1'b0;
            r_we       <= 1'b0;
            r_funct3   <= 3'd0;
            r_addr     <= '0;
            r_wdata    <= 32'd0;
            r_cnt      <= 4'd0;
            r_starve   <= '0;
            r_if_rdata <= 32'd0;
            r_dm_rdata <= 32'd0;
        end else if (w_start) begin
            r_own_dm <= w_grant_dm;
            r_we     <= w_grant_dm & dm_we;
            r_funct3 <= w_grant_dm ? dm_funct3 : 3'b010;
            r_addr   <= w_grant_dm ? dm_addr : if_addr;
            r_wdata  <= w_grant_dm ? dm_wdata : 32'd0;
            r_cnt    <= LAT_LAST;
            // count data grants that made a waiting fetch wait longer
            r_starve <= !w_grant_dm ? '0 :
                        (if_req && r_starve != STARVE_MAX) ? r_starve + SW'(1) : r_starve;
        end else if (w_access) begin
            r_cnt <= w_last ? r_cnt : r_cnt - 4'd1;
            if (w_last && !r_we && r_own_dm)
                r_dm_rdata <= mem_rdata;
            if (w_last && !r_we && !r_own_dm)
                r_if_rdata <= mem_rdata;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed stimulus on MEM_LAT=1 and MEM_LAT=3 instances, checked against a cycle-count model
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_req[2], dm_req[2], dm_we[2], if_ready[2], dm_ready[2];
    logic        mem_en[2], mem_we[2], stall_if[2], stall_mem[2], busy[2];
    logic [6:0]  if_addr[2], dm_addr[2], mem_addr[2];
    logic [2:0]  dm_funct3[2], mem_funct3[2];
    logic [31:0] dm_wdata[2], if_rdata[2], dm_rdata[2], mem_wdata[2], mem_rdata[2];
    logic [31:0] mem_img[32];
    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        mem_port_arbiter #(.ADDR_W(7), .MEM_LAT(g == 0 ? 1 : 3), .MAX_STARVE(4)) u_dut (
            .clk(clk), .rst(rst),
            .if_req(if_req[g]), .if_addr(if_addr[g]), .if_ready(if_ready[g]), .if_rdata(if_rdata[g]),
            .dm_req(dm_req[g]), .dm_we(dm_we[g]), .dm_funct3(dm_funct3[g]), .dm_addr(dm_addr[g]),
            .dm_wdata(dm_wdata[g]), .dm_ready(dm_ready[g]), .dm_rdata(dm_rdata[g]),
            .mem_en(mem_en[g]), .mem_we(mem_we[g]), .mem_funct3(mem_funct3[g]), .mem_addr(mem_addr[g]),
            .mem_wdata(mem_wdata[g]), .mem_rdata(mem_rdata[g]),
            .stall_if(stall_if[g]), .stall_mem(stall_mem[g]), .busy(busy[g])
        );
        assign mem_rdata[g] = mem_en[g] ? mem_img[mem_addr[g][6:2]] : 32'h0;
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic go();
        @(posedge clk);
        #1;
    endtask

    task automatic ne(input int n);
        repeat (n) @(negedge clk);
    endtask

    // model: an access granted in idle cycle t owns cycles t+1..t+lat, responds at t+lat+1
    bit          m_busy[2], m_own[2], m_we[2];
    int          m_start[2], m_starve[2];
    logic [6:0]  m_addr[2];
    logic [2:0]  m_f3[2];
    logic [31:0] m_wd[2], m_ird[2], m_drd[2];

    initial begin
        int lat, ph;
        bit acc, rsp, eir, edr, d;
        string p;
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                lat = k == 0 ? 1 : 3;
                if (rst) begin
                    m_busy[k] = 0;
                    m_starve[k] = 0;
                    m_ird[k] = 0;
                    m_drd[k] = 0;
                end
                ph  = m_busy[k] ? cyc - m_start[k] : 0;
                acc = m_busy[k] && ph >= 1 && ph <= lat;
                rsp = m_busy[k] && ph == lat + 1;
                eir = rsp && !m_own[k];
                edr = rsp && m_own[k];
                p = $sformatf("u%0d@%0d", k, cyc);
                chk({p, ".busy"}, 32'(busy[k]), 32'(m_busy[k]));
                chk({p, ".mem_en"}, 32'(mem_en[k]), 32'(acc));
                chk({p, ".mem_we"}, 32'(mem_we[k]), 32'(acc && m_we[k]));
                chk({p, ".mem_funct3"}, 32'(mem_funct3[k]), acc ? 32'(m_f3[k]) : 32'd0);
                chk({p, ".mem_addr"}, 32'(mem_addr[k]), acc ? 32'(m_addr[k]) : 32'd0);
                chk({p, ".mem_wdata"}, mem_wdata[k], acc ? m_wd[k] : 32'd0);
                chk({p, ".if_ready"}, 32'(if_ready[k]), 32'(eir));
                chk({p, ".dm_ready"}, 32'(dm_ready[k]), 32'(edr));
                chk({p, ".if_rdata"}, if_rdata[k], m_ird[k]);
                chk({p, ".dm_rdata"}, dm_rdata[k], m_drd[k]);
                chk({p, ".stall_if"}, 32'(stall_if[k]), 32'(!rst && if_req[k] && !eir));
                chk({p, ".stall_mem"}, 32'(stall_mem[k]), 32'(!rst && dm_req[k] && !edr));
                if (!rst) begin
                    if (!m_busy[k]) begin
                        if (if_req[k] || dm_req[k]) begin
                            d = dm_req[k] && !(if_req[k] && m_starve[k] == 4);
                            m_busy[k]  = 1;
                            m_start[k] = cyc;
                            m_own[k]   = d;
                            m_we[k]    = d && dm_we[k];
                            m_addr[k]  = d ? dm_addr[k] : if_addr[k];
                            m_f3[k]    = d ? dm_funct3[k] : 3'b010;
                            m_wd[k]    = d ? dm_wdata[k] : 32'd0;
                            m_starve[k] = !d ? 0 : (if_req[k] && m_starve[k] < 4) ? m_starve[k] + 1 : m_starve[k];
                        end
                    end else if (ph == lat && !m_we[k]) begin
                        if (m_own[k])
                            m_drd[k] = mem_img[m_addr[k][6:2]];
                        else
                            m_ird[k] = mem_img[m_addr[k][6:2]];
                    end else if (ph == lat + 1) begin
                        m_busy[k] = 0;
                    end
                end
            end
            cyc++;
        end
    end

    initial begin
        for (int i = 0; i < 32; i++)
            mem_img[i] = 32'hC0DE0000 | 32'(i);
        mem_img[1]  = 32'h00500093;
        mem_img[2]  = 32'h12345678;
        mem_img[16] = 32'h0000002A;
        for (int k = 0; k < 2; k++) begin
            if_req[k] = 0; if_addr[k] = 0; dm_req[k] = 0; dm_we[k] = 0;
            dm_funct3[k] = 0; dm_addr[k] = 0; dm_wdata[k] = 0;
        end
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy[0]), 32'd0);
        chk("rst_mem_en", 32'(mem_en[1]), 32'd0);
        chk("rst_if_rdata", if_rdata[0], 32'd0);
        go();
        rst = 1'b0;
        ne(2);
        // fetch alone, MEM_LAT=1
        go();
        if_req[0] = 1; if_addr[0] = 7'h04;
        ne(1);
        chk("t1_stall_c0", 32'(stall_if[0]), 32'd1);
        chk("t1_en_c0", 32'(mem_en[0]), 32'd0);
        ne(1);
        chk("t1_en_c1", 32'(mem_en[0]), 32'd1);
        chk("t1_addr_c1", 32'(mem_addr[0]), 32'h04);
        chk("t1_f3_c1", 32'(mem_funct3[0]), 32'd2);
        chk("t1_stall_c1", 32'(stall_if[0]), 32'd1);
        ne(1);
        chk("t1_ready_c2", 32'(if_ready[0]), 32'd1);
        chk("t1_rdata_c2", if_rdata[0], 32'h00500093);
        chk("t1_stall_c2", 32'(stall_if[0]), 32'd0);
        go();
        if_req[0] = 0;
        ne(2);
        // fetch and load together: data first
        go();
        if_req[0] = 1; if_addr[0] = 7'h04;
        dm_req[0] = 1; dm_addr[0] = 7'h40; dm_funct3[0] = 3'b010; dm_we[0] = 0; dm_wdata[0] = 0;
        ne(2);
        chk("t2_addr_c1", 32'(mem_addr[0]), 32'h40);
        ne(1);
        chk("t2_dready_c2", 32'(dm_ready[0]), 32'd1);
        chk("t2_drdata_c2", dm_rdata[0], 32'h2A);
        chk("t2_iready_c2", 32'(if_ready[0]), 32'd0);
        go();
        dm_req[0] = 0;
        ne(1);
        chk("t2_busy_c3", 32'(busy[0]), 32'd0);
        ne(1);
        chk("t2_addr_c4", 32'(mem_addr[0]), 32'h04);
        ne(1);
        chk("t2_iready_c5", 32'(if_ready[0]), 32'd1);
        go();
        if_req[0] = 0;
        ne(2);
        // both held: four data grants, then fetch, then data again
        go();
        if_req[0] = 1; dm_req[0] = 1;
        for (int g = 0; g < 6; g++) begin
            ne(2);
            chk($sformatf("t4_grant%0d_addr", g), 32'(mem_addr[0]), g == 4 ? 32'h04 : 32'h40);
            ne(1);
            chk($sformatf("t4_grant%0d_ready", g), g == 4 ? 32'(if_ready[0]) : 32'(dm_ready[0]), 32'd1);
        end
        go();
        if_req[0] = 0; dm_req[0] = 0;
        // ten idle cycles
        ne(10);
        chk("t6_busy", 32'(busy[0]), 32'd0);
        chk("t6_en", 32'(mem_en[0]), 32'd0);
        chk("t6_stall", 32'({stall_if[0], stall_mem[0]}), 32'd0);
        chk("t6_irdata", if_rdata[0], 32'h00500093);
        chk("t6_drdata", dm_rdata[0], 32'h2A);
        // MEM_LAT=3: load, then store must leave dm_rdata alone
        go();
        dm_req[1] = 1; dm_addr[1] = 7'h40; dm_funct3[1] = 3'b010; dm_we[1] = 0; dm_wdata[1] = 0;
        ne(5);
        chk("t3_load_ready", 32'(dm_ready[1]), 32'd1);
        chk("t3_load_rdata", dm_rdata[1], 32'h2A);
        go();
        dm_req[1] = 0;
        ne(1);
        go();
        dm_req[1] = 1; dm_we[1] = 1; dm_addr[1] = 7'h10; dm_wdata[1] = 32'hDEADBEEF; dm_funct3[1] = 3'b000;
        ne(1);
        chk("t3_en_c0", 32'(mem_en[1]), 32'd0);
        for (int c = 1; c <= 3; c++) begin
            ne(1);
            chk($sformatf("t3_en_c%0d", c), 32'(mem_en[1]), 32'd1);
            chk($sformatf("t3_we_c%0d", c), 32'(mem_we[1]), 32'd1);
            chk($sformatf("t3_addr_c%0d", c), 32'(mem_addr[1]), 32'h10);
            chk($sformatf("t3_wdata_c%0d", c), mem_wdata[1], 32'hDEADBEEF);
            chk($sformatf("t3_f3_c%0d", c), 32'(mem_funct3[1]), 32'd0);
        end
        ne(1);
        chk("t3_en_c4", 32'(mem_en[1]), 32'd0);
        chk("t3_ready_c4", 32'(dm_ready[1]), 32'd1);
        chk("t3_rdata_c4", dm_rdata[1], 32'h2A);
        go();
        dm_req[1] = 0; dm_we[1] = 0;
        ne(1);
        // asynchronous reset in the middle of a 3-cycle fetch
        go();
        if_req[1] = 1; if_addr[1] = 7'h08;
        ne(2);
        @(posedge clk);
        #2;
        chk("t5_en_pre", 32'(mem_en[1]), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("t5_en_rst", 32'(mem_en[1]), 32'd0);
        chk("t5_busy_rst", 32'(busy[1]), 32'd0);
        chk("t5_stall_rst", 32'(stall_if[1]), 32'd0);
        @(posedge clk);
        go();
        rst = 1'b0;
        ne(1);
        chk("t5_en_r0", 32'(mem_en[1]), 32'd0);
        chk("t5_ready_r0", 32'(if_ready[1]), 32'd0);
        chk("t5_stall_r0", 32'(stall_if[1]), 32'd1);
        ne(1);
        chk("t5_en_r1", 32'(mem_en[1]), 32'd1);
        chk("t5_addr_r1", 32'(mem_addr[1]), 32'h08);
        ne(2);
        chk("t5_en_r3", 32'(mem_en[1]), 32'd1);
        ne(1);
        chk("t5_ready_r4", 32'(if_ready[1]), 32'd1);
        chk("t5_rdata_r4", if_rdata[1], 32'h12345678);
        go();
        if_req[1] = 0;
        ne(3);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
